// File: rtl/ise_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ise_pkg
//  Description : Shared constants, color codes, FSM state encoding and the
//                result record used by the image sorting engine feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ise_pkg;

  localparam int N_IMG    = 32;     // images per run
  localparam int N_PIX    = 16384;  // pixels per image
  localparam int BUSY_TMO = 64;     // cycles allowed for busy to rise

  localparam int IW = $clog2(N_IMG);  // image index width
  localparam int PW = 14;             // pixel field width inside mem_addr
  localparam int AW = IW + PW;        // pixel memory address width
  localparam int DW = 24;             // {R,G,B}
  localparam int CW = 2;              // color code width
  localparam int WW = IW + 1;         // result write counter, reaches N_IMG

  typedef enum logic [CW-1:0] {
    COLOR_RED   = 2'd0,
    COLOR_GREEN = 2'd1,
    COLOR_BLUE  = 2'd2
  } color_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_COLLECT = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef struct packed {
    logic [CW-1:0] color;
    logic [IW-1:0] index;
  } result_t;

endpackage
`default_nettype wire

// File: rtl/ise_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : ise_result_checker
//  Description : Captures the engine's sorted result beats into a buffer and
//                checks that colors are nondecreasing and that every image
//                index shows up exactly once.
//  Revision    : 1.0 - initial release
//  Ports       : clk, reset        clock, async active-high reset
//                clear_i           restart capture (counters, mask, flags)
//                collect_en_i      beats are accepted only while high
//                out_valid_i       result beat strobe
//                color_i, index_i  result beat payload
//                rd_addr_i         buffer read address
//                rd_color_o/rd_index_o  combinational buffer read data
//                last_beat_o       the final (N_IMG-th) beat is accepted now
//                err_order_o       a beat's color was below the previous one
//                err_dup_o         repeated or missing image index
// ============================================================================
module ise_result_checker
  import ise_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          collect_en_i,
  input  logic          out_valid_i,
  input  logic [CW-1:0] color_i,
  input  logic [IW-1:0] index_i,
  input  logic [IW-1:0] rd_addr_i,
  output logic [CW-1:0] rd_color_o,
  output logic [IW-1:0] rd_index_o,
  output logic          last_beat_o,
  output logic          err_order_o,
  output logic          err_dup_o
);

  localparam logic [WW-1:0] WCNT_FULL = WW'(N_IMG);
  localparam logic [WW-1:0] WCNT_LAST = WW'(N_IMG - 1);

  result_t             res_q [N_IMG];
  logic [WW-1:0]       wcnt_q;
  logic [N_IMG-1:0]    seen_q;
  logic [CW-1:0]       prev_color_q;
  logic                err_order_q;
  logic                err_dup_q;

  logic                w_accept;
  logic [N_IMG-1:0]    w_onehot;
  logic [N_IMG-1:0]    w_seen_d;
  result_t             w_rd;

  // The wcnt guard keeps a stray extra beat from overwriting entry 0.
  assign w_accept    = collect_en_i && out_valid_i && (wcnt_q < WCNT_FULL);
  assign w_onehot    = N_IMG'(1) << index_i;
  assign w_seen_d    = seen_q | w_onehot;
  assign last_beat_o = w_accept && (wcnt_q == WCNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q       <= '0;
      seen_q       <= '0;
      prev_color_q <= COLOR_RED;
      err_order_q  <= 1'b0;
      err_dup_q    <= 1'b0;
    end else if (clear_i) begin
      wcnt_q       <= '0;
      seen_q       <= '0;
      prev_color_q <= COLOR_RED;
      err_order_q  <= 1'b0;
      err_dup_q    <= 1'b0;
    end else if (w_accept) begin
      wcnt_q       <= wcnt_q + WW'(1);
      seen_q       <= w_seen_d;
      prev_color_q <= color_i;
      // The first beat has no predecessor to compare against.
      if ((wcnt_q != '0) && (color_i < prev_color_q))
        err_order_q <= 1'b1;
      if ((seen_q & w_onehot) != '0)
        err_dup_q <= 1'b1;
      // On the closing beat every image must have been reported.
      if (last_beat_o && (w_seen_d != '1))
        err_dup_q <= 1'b1;
    end
  end

  // Buffer storage carries no reset; contents after a reset are undefined.
  always_ff @(posedge clk) begin
    if (w_accept)
      res_q[wcnt_q[IW-1:0]] <= '{color: color_i, index: index_i};
  end

  assign w_rd        = res_q[rd_addr_i];
  assign rd_color_o  = w_rd.color;
  assign rd_index_o  = w_rd.index;
  assign err_order_o = err_order_q;
  assign err_dup_o   = err_dup_q;

endmodule
`default_nettype wire

// File: rtl/ise_image_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : ise_image_feeder
//  Description : Host-side initiator for the image sorting engine. Streams
//                N_IMG images from pixel memory to the engine, waits for the
//                engine's busy handshake after each image, then captures and
//                checks the sorted results.
//  Revision    : 1.0 - initial release
//  Ports       : clk, reset (async, active-high), start (1-cycle pulse)
//                mem_rd/mem_addr/mem_rdata  pixel memory, 1-cycle read latency
//                busy                       engine busy
//                image_in_index/pixel_in/pix_valid  pixel stream to engine
//                out_valid/color_index/image_out_index  engine result beats
//                rd_addr/rd_color/rd_index  result buffer read port
//                done, err_tmo, err_order, err_dup  run status
// ============================================================================
module ise_image_feeder
  import ise_pkg::*;
#(
  parameter int PIX_PER_IMG = N_PIX,
  parameter int TMO_LIMIT   = BUSY_TMO
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          busy,
  output logic [IW-1:0] image_in_index,
  output logic [DW-1:0] pixel_in,
  output logic          pix_valid,
  input  logic          out_valid,
  input  logic [CW-1:0] color_index,
  input  logic [IW-1:0] image_out_index,
  input  logic [IW-1:0] rd_addr,
  output logic [CW-1:0] rd_color,
  output logic [IW-1:0] rd_index,
  output logic          done,
  output logic          err_tmo,
  output logic          err_order,
  output logic          err_dup
);

  localparam int            TW       = $clog2(TMO_LIMIT + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_IMG - 1);
  localparam logic [IW-1:0] IMG_LAST = IW'(N_IMG - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIMIT - 1);

  state_e          state_q;
  logic [IW-1:0]   img_q;
  logic [PW-1:0]   pix_q;
  logic [TW-1:0]   tmo_q;
  logic            mem_rd_q;
  logic            rvalid_q;
  logic [DW-1:0]   pixel_q;
  logic            pix_valid_q;
  logic            done_q;
  logic            err_tmo_q;

  logic            w_start_ok;
  logic            w_collect;
  logic            w_last_beat;

  assign w_start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign w_collect  = (state_q == ST_COLLECT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      img_q       <= '0;
      pix_q       <= '0;
      tmo_q       <= '0;
      mem_rd_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      pixel_q     <= '0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      // Read data returns one cycle after mem_rd and is registered on return,
      // so each pixel appears on pixel_in two cycles after its read strobe.
      rvalid_q    <= mem_rd_q;
      pix_valid_q <= rvalid_q;
      if (rvalid_q)
        pixel_q <= mem_rdata;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            state_q   <= ST_STREAM;
            img_q     <= '0;
            pix_q     <= '0;
            mem_rd_q  <= 1'b1;
            done_q    <= 1'b0;
            err_tmo_q <= 1'b0;
          end
        end
        ST_STREAM: begin
          // busy is not looked at here; the engine only raises it after a
          // complete image.
          if (pix_q == PIX_LAST) begin
            state_q  <= ST_DRAIN;
            mem_rd_q <= 1'b0;
          end else begin
            pix_q <= pix_q + PW'(1);
          end
        end
        ST_DRAIN: begin
          state_q <= ST_WAIT_HI;
          tmo_q   <= '0;
        end
        ST_WAIT_HI: begin
          if (busy) begin
            state_q <= ST_WAIT_LO;
          end else if (tmo_q == TMO_LAST) begin
            // TMO_LIMIT cycles have now elapsed without busy.
            state_q   <= ST_DONE;
            err_tmo_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!busy) begin
            pix_q <= '0;
            if (img_q == IMG_LAST) begin
              img_q   <= '0;
              state_q <= ST_COLLECT;
            end else begin
              img_q    <= img_q + IW'(1);
              state_q  <= ST_STREAM;
              mem_rd_q <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (w_last_beat) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  ise_result_checker u_checker (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (w_start_ok),
    .collect_en_i (w_collect),
    .out_valid_i  (out_valid),
    .color_i      (color_index),
    .index_i      (image_out_index),
    .rd_addr_i    (rd_addr),
    .rd_color_o   (rd_color),
    .rd_index_o   (rd_index),
    .last_beat_o  (w_last_beat),
    .err_order_o  (err_order),
    .err_dup_o    (err_dup)
  );

  assign mem_rd         = mem_rd_q;
  assign mem_addr       = {img_q, pix_q};
  assign image_in_index = img_q;
  assign pixel_in       = pixel_q;
  assign pix_valid      = pix_valid_q;
  assign done           = done_q;
  assign err_tmo        = err_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_ise_image_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ise_image_feeder
//  Description : Directed self-checking bench for ise_image_feeder with a
//                pixel memory model and a busy-handshake engine model.
//                Images are shortened to NP pixels to keep runs brief.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ise_image_feeder;

  localparam int NP  = 16;
  localparam int TMO = 64;
  localparam int NI  = 32;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_rd;
  logic [18:0] mem_addr;
  logic [23:0] mem_rdata;
  logic        busy;
  logic [4:0]  image_in_index;
  logic [23:0] pixel_in;
  logic        pix_valid;
  logic        out_valid;
  logic [1:0]  color_index;
  logic [4:0]  image_out_index;
  logic [4:0]  rd_addr;
  logic [1:0]  rd_color;
  logic [4:0]  rd_index;
  logic        done;
  logic        err_tmo;
  logic        err_order;
  logic        err_dup;

  int n_vec;
  int n_err;

  // Engine / memory model state
  int          eng_imgs;
  logic        busy_en;
  int          pcnt;
  int          hi_wait;
  int          lo_wait;
  logic        req_v;
  logic [18:0] req_a;

  logic [1:0]  bc [NI];
  logic [4:0]  bi [NI];

  ise_image_feeder #(
    .PIX_PER_IMG (NP),
    .TMO_LIMIT   (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .busy            (busy),
    .image_in_index  (image_in_index),
    .pixel_in        (pixel_in),
    .pix_valid       (pix_valid),
    .out_valid       (out_valid),
    .color_index     (color_index),
    .image_out_index (image_out_index),
    .rd_addr         (rd_addr),
    .rd_color        (rd_color),
    .rd_index        (rd_index),
    .done            (done),
    .err_tmo         (err_tmo),
    .err_order       (err_order),
    .err_dup         (err_dup)
  );

  always #5 clk = ~clk;

  // Memory content: img*256 plus the low pixel byte.
  function automatic logic [23:0] pix_data(input logic [18:0] a);
    return {11'd0, a[18:14], a[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Main thread acts 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_collect(input string tag);
    int n;
    n = 0;
    while (eng_imgs < NI && n < NI * (NP + 40)) begin
      step();
      n++;
    end
    chk(tag, eng_imgs, NI);
    step();
  endtask

  task automatic send_beats();
    for (int i = 0; i < NI; i++) begin
      out_valid       = 1'b1;
      color_index     = bc[i];
      image_out_index = bi[i];
      step();
    end
    out_valid = 1'b0;
  endtask

  // Memory (1-cycle latency) and engine (busy 3 cycles after the last pixel,
  // held for 10 cycles). Acts 1 time unit after each rising edge.
  initial begin
    busy      = 1'b0;
    mem_rdata = '0;
    pcnt      = 0;
    hi_wait   = 0;
    lo_wait   = 0;
    req_v     = 1'b0;
    req_a     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        busy      = 1'b0;
        mem_rdata = '0;
        pcnt      = 0;
        hi_wait   = 0;
        lo_wait   = 0;
        req_v     = 1'b0;
      end else begin
        mem_rdata = req_v ? pix_data(req_a) : 24'h0;
        req_v     = mem_rd;
        req_a     = mem_addr;
        if (hi_wait > 0) begin
          hi_wait--;
          if (hi_wait == 0) begin
            busy    = 1'b1;
            lo_wait = 10;
          end
        end else if (lo_wait > 0) begin
          lo_wait--;
          if (lo_wait == 0) begin
            busy = 1'b0;
            eng_imgs++;
          end
        end
        if (pix_valid) begin
          pcnt++;
          if (pcnt == NP) begin
            pcnt = 0;
            if (busy_en) hi_wait = 3;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int n;
    clk             = 1'b0;
    reset           = 1'b1;
    start           = 1'b0;
    out_valid       = 1'b0;
    color_index     = '0;
    image_out_index = '0;
    rd_addr         = '0;
    busy_en         = 1'b1;
    eng_imgs        = 0;
    n_vec           = 0;
    n_err           = 0;

    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pv", pix_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_tmo, err_order, err_dup}, 0);
    reset = 1'b0;
    step();

    // ---------------- run A: normal run ----------------
    eng_imgs        = 0;
    out_valid       = 1'b1;   // stray beats outside COLLECT must be ignored
    color_index     = 2'd2;
    image_out_index = 5'd5;
    pulse_start();
    chk("a_rd_e0", mem_rd, 1);
    chk("a_addr_e0", mem_addr, 0);
    step();
    chk("a_pv_e1", pix_valid, 0);
    for (int p = 0; p < 4; p++) begin
      step();
      chk("a_pv_px", pix_valid, 1);
      chk("a_pixel", pixel_in, p);
    end
    out_valid = 1'b0;
    cnt = 4;
    n   = 0;
    while (n < 2 * NP) begin
      step();
      n++;
      if (!pix_valid) break;
      cnt++;
    end
    chk("a_pv_count", cnt, NP);
    chk("a_img0_idx", image_in_index, 0);
    n = 0;
    while (!busy && n < 100) begin step(); n++; end
    chk("a_busy_hi", busy, 1);
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    chk("a_busy_lo", busy, 0);
    step();
    chk("a_img1_rd", mem_rd, 1);
    chk("a_img1_addr", mem_addr, 19'h04000);
    chk("a_img1_idx", image_in_index, 1);
    pulse_start();            // mid-run start is ignored
    chk("a_start_ign", mem_addr, 19'h04001);
    step();
    chk("a_img1_px0", pixel_in, 24'h000100);
    for (int i = 0; i < NI; i++) begin
      bc[i] = (i < 11) ? 2'd0 : (i < 21) ? 2'd1 : 2'd2;
      bi[i] = 5'((i * 7) % NI);
    end
    wait_collect("a_collect");
    send_beats();
    chk("a_done", done, 1);
    chk("a_errs", {err_tmo, err_order, err_dup}, 0);
    rd_addr = 5'd31;
    #1;
    chk("a_rd31", {rd_color, rd_index}, {2'd2, 5'd25});
    rd_addr = 5'd11;
    #1;
    chk("a_rd11", {rd_color, rd_index}, {2'd1, 5'd13});

    // ---------------- run B: order violation ----------------
    eng_imgs = 0;
    pulse_start();
    chk("b_done_clr", done, 0);
    for (int i = 0; i < NI; i++) begin
      bc[i] = (i == 0) ? 2'd0 : (i == 2) ? 2'd1 : 2'd2;
      bi[i] = 5'((i * 7) % NI);
    end
    wait_collect("b_collect");
    send_beats();
    chk("b_done", done, 1);
    chk("b_order", err_order, 1);
    chk("b_dup", err_dup, 0);

    // ---------------- run C: duplicate index ----------------
    eng_imgs = 0;
    pulse_start();
    chk("c_order_clr", err_order, 0);
    for (int i = 0; i < NI; i++) begin
      bc[i] = 2'd1;
      bi[i] = (i == 8) ? 5'd7 : 5'(i);
    end
    wait_collect("c_collect");
    send_beats();
    chk("c_done", done, 1);
    chk("c_dup", err_dup, 1);
    chk("c_order", err_order, 0);

    // ---------------- run D: busy never rises ----------------
    busy_en  = 1'b0;
    eng_imgs = 0;
    pulse_start();
    chk("d_dup_clr", err_dup, 0);
    n = 0;
    while (mem_rd && n < NP + 10) begin step(); n++; end
    chk("d_rd_fall", mem_rd, 0);
    cnt = 0;
    while (!done && cnt < 200) begin step(); cnt++; end
    chk("d_tmo_cycles", cnt, TMO + 1);
    chk("d_err_tmo", err_tmo, 1);
    chk("d_img_idx", image_in_index, 0);

    // ---------------- run E: reset mid-stream of img5 ----------------
    busy_en  = 1'b1;
    eng_imgs = 0;
    pulse_start();
    chk("e_tmo_clr", err_tmo, 0);
    n = 0;
    while (!(image_in_index == 5'd5 && mem_rd) && n < 6 * (NP + 40)) begin step(); n++; end
    chk("e_at_img5", image_in_index, 5);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("e_rst_rd", mem_rd, 0);
    chk("e_rst_idx", image_in_index, 0);
    chk("e_rst_done", {done, pix_valid}, 0);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    chk("e_restart", {mem_rd, mem_addr}, {1'b1, 19'h00000});
    step();
    step();
    chk("e_px0", {pix_valid, pixel_in}, {1'b1, 24'h000000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
